// File: rtl/mdu_pkg.sv
// Shared types, constants and sign helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP
  } state_e;

  localparam logic [5:0]  ITER_LAST = 6'd31;
  localparam logic [31:0] DIV0_LO   = 32'hFFFFFFFF;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude for signed ops; unsigned ops pass the raw operand through.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One multiplier/quotient bit per CALC cycle on a shared 64-bit shift datapath.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  op_e              op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;

  logic             is_div;
  logic             sgn;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
  logic [2*WIDTH-1:0] prod_fix;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign sgn    = ~op[0];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;

    mul_sum  = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // When rem_ge holds the true difference is below the divisor, so the low bits suffice.
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    prod_fix = neg_res_q ? neg64({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          count_d   = '0;
          op_d      = op_e'(op);
          neg_res_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = sgn & a[WIDTH-1];
          div0_d    = op[1] & (b == '0);
          acc_hi_d  = '0;
          if (op[1]) begin
            opnd_d   = abs32(b, sgn);
            acc_lo_d = abs32(a, sgn);
          end else begin
            opnd_d   = abs32(a, sgn);
            acc_lo_d = abs32(b, sgn);
          end
        end else begin
          if (mthi) hi_d = wd;
          if (mtlo) lo_d = wd;
        end
      end
      S_CALC: begin
        if (is_div) begin
          acc_hi_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (count_q == ITER_LAST) begin
          state_d = S_FIXUP;
          count_d = '0;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      S_FIXUP: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div) begin
          // Divide by zero leaves |a| as remainder; the dividend-sign fixup restores a itself.
          lo_d = div0_q ? DIV0_LO : (neg_res_q ? neg32(acc_lo_q) : acc_lo_q);
          hi_d = neg_rem_q ? neg32(acc_hi_q) : acc_hi_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q      <= op_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    div0_q    <= div0_d;
    opnd_q    <= opnd_d;
    acc_hi_q  <= acc_hi_d;
    acc_lo_q  <= acc_lo_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // inj: 0 none, 1 start MULTU 2*2 in cycle 10, 2 mthi 0xDEAD in cycle 10, 3 mthi with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, input string tag);
    int n;
    logic [31:0] hi_before;
    hi_before = hi;
    op = o; a = x; b = y; start = 1'b1;
    if (inj == 3) begin mthi = 1'b1; wd = 32'hDEAD; end
    tick();
    start = 1'b0; mthi = 1'b0;
    op = ~o; a = ~x; b = ~y;
    n = 1;
    chk_eq({tag, "_busy1"}, {63'd0, busy}, 64'd1);
    if (inj == 3) chk_eq({tag, "_hi_nowrite"}, {32'd0, hi}, {32'd0, hi_before});
    while (!done && n < 40) begin
      if (n == 33) chk_eq({tag, "_busy33"}, {63'd0, busy}, 64'd1);
      if (n == 10 && inj == 1) begin start = 1'b1; op = MULTU; a = 32'd2; b = 32'd2; end
      if (n == 10 && inj == 2) begin mthi = 1'b1; wd = 32'hDEAD; end
      tick();
      start = 1'b0; mthi = 1'b0;
      n++;
    end
    chk_eq({tag, "_latency"}, 64'(n), 64'd34);
    chk_eq({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wd = '0;
    tick(); tick();
    rst = 1'b0;
    chk_eq("rst_busy", {63'd0, busy}, 64'd0);
    chk_eq("rst_done", {63'd0, done}, 64'd0);
    chk_eq("rst_hilo", {hi, lo}, 64'd0);

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
    chk_eq("multu_max_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    tick();
    chk_eq("done_one_cycle", {63'd0, done}, 64'd0);
    chk_eq("hold_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    run_op(MULT, 32'hFFFFFFFD, 32'd7, 0, "mult_neg");
    chk_eq("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    // Started in the done cycle of the previous op.
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 0, "div_neg");
    chk_eq("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(DIVU, 32'h12345678, 32'd0, 0, "divu_zero");
    chk_eq("divu_zero_hilo", {hi, lo}, 64'h12345678_FFFFFFFF);
    run_op(DIV, 32'hFFFFFFF9, 32'd0, 0, "div_zero_neg");
    chk_eq("div_zero_neg_hilo", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
    chk_eq("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

    run_op(DIVU, 32'd100, 32'd7, 1, "divu_start_ign");
    chk_eq("divu_start_ign_hilo", {hi, lo}, {32'd2, 32'd14});
    tick();
    chk_eq("no_queued_op", {62'd0, busy, done}, 64'd0);
    run_op(DIVU, 32'd100, 32'd7, 2, "divu_mthi_ign");
    chk_eq("divu_mthi_ign_hilo", {hi, lo}, {32'd2, 32'd14});

    tick();
    mtlo = 1'b1; wd = 32'hCAFEF00D;
    tick();
    mtlo = 1'b0;
    chk_eq("mtlo_idle", {hi, lo}, {32'd2, 32'hCAFEF00D});
    mthi = 1'b1; mtlo = 1'b1; wd = 32'h0BADBEEF;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk_eq("mthi_mtlo_both", {hi, lo}, 64'h0BADBEEF_0BADBEEF);

    run_op(MULTU, 32'd3, 32'd5, 3, "start_mthi");
    chk_eq("start_mthi_hilo", {hi, lo}, {32'd0, 32'd15});

    // Reset mid-operation: result discarded, no done pulse.
    begin
      int n;
      int seen_done;
      mtlo = 1'b1; wd = 32'h55AA55AA;
      tick();
      mtlo = 1'b0;
      op = MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (n < 20) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("midrst_busy", {63'd0, busy}, 64'd0);
      chk_eq("midrst_hilo", {hi, lo}, 64'd0);
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) seen_done = 1;
        tick();
      end
      chk_eq("midrst_no_done", 64'(seen_done), 64'd0);
    end
    run_op(MULTU, 32'd3, 32'd5, 0, "after_rst");
    chk_eq("after_rst_hilo", {hi, lo}, {32'd0, 32'd15});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit executing MULT, MULTU, DIV and DIVU.
- Sits directly downstream of the register file: it consumes the rs/rt read values and holds the architectural HI/LO pair.
- The execute stage issues a start pulse and stalls on busy; MFHI/MFLO read hi/lo directly.
- MTHI/MTLO write hi/lo through dedicated write ports.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  operand rs (dividend or multiplicand).
- b  in  WIDTH  operand rt (divisor or multiplier).
- mthi  in  1  write wd into hi.
- mtlo  in  1  write wd into lo.
- wd  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset: rst high at a clock edge forces state=IDLE, hi=0, lo=0, busy=0, done=0 and count=0.
  - Reset applies in any state, including mid-operation; the partial result is discarded.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, 32 iterations, 6-bit count runs 0..31.
  - FIXUP: busy=1, one cycle.
- IDLE -> CALC when start=1.
  - Latch op, sign flags and |a|, |b| into internal registers.
  - |x| is two's-complement negate when the signed op has x[31]=1; unsigned ops take operands raw.
- CALC -> FIXUP after the iteration at count=31.
- FIXUP -> IDLE unconditionally.
  - Apply sign correction, write hi/lo, set done=1 for the next cycle only.
- Latency: cycle 0 is the start-sample edge. busy=1 in cycles 1..33. hi/lo update and done=1 in cycle 34, with busy=0 in that same cycle.
- A new start may be accepted in the same cycle that done=1.
- Multiply:
  - Radix-2 shift-add on a 64-bit accumulator {hi_acc, lo_acc}, one multiplier bit per CALC cycle.
  - Signed result is negated as a 64-bit value when sign(a) XOR sign(b).
- Divide:
  - Restoring division, one quotient bit per cycle; 33-bit partial remainder.
  - Quotient is truncated toward zero. Remainder takes the sign of the dividend.
  - 0x80000000 / -1 (signed) yields lo=0x80000000, hi=0x00000000.
- Divide by zero (b=0, DIV or DIVU): same 34-cycle latency, result hi=a (original, unmodified), lo=0xFFFFFFFF; no exception.
- start while busy=1: ignored; no queueing.
- mthi/mtlo:
  - Effective only in IDLE; the write takes effect at the next edge.
  - Ignored while busy=1, so an in-flight result is never corrupted.
  - If start=1 in the same IDLE cycle, start wins and mthi/mtlo are dropped.
  - mthi and mtlo together both write wd.
- hi/lo hold their value between updates. Intermediate CALC values never appear on hi/lo.
- op and operand inputs may change freely after the start-sample edge.

Decomposition:
- Package mdu_pkg:
  - op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (S_IDLE, S_CALC, S_FIXUP);
  - ITER_LAST=31;
  - DIV0_LO=32'hFFFFFFFF.
- No sub-module. FSM, counter and shared 64-bit shift datapath stay in one module; the negate/abs helpers are functions in mdu_pkg.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33; done at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678 b=0 -> after 34 cycles hi=0x12345678, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Issue DIVU 100/7, then in cycle 10:
  - pulse start with op=MULTU, a=b=2 -> ignored; hi=2, lo=14 at cycle 34.
  - assert mthi wd=0xDEAD -> ignored; hi=2, lo=14 at cycle 34.
- In IDLE:
  - mtlo wd=0xCAFEF00D -> lo=0xCAFEF00D next cycle, hi unchanged.
  - start and mthi in the same cycle -> hi not written; operation runs.
- Start MULTU 3*5, assert rst in cycle 20 -> next cycle busy=0, hi=lo=0, done never pulses. A fresh start then completes normally with lo=15.
